// File: rtl/controlador_banco.sv
// rtl/controlador_banco.sv - round-robin sequencer for the 2**SEL x LARGURA register bank
// Optional: define PROTEGE_R0_EN to make R0 a hard-wired zero register.
module controlador_banco #(
   parameter int LARGURA = 16,
   parameter int SEL     = 3
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  req0,
   input  logic                  req1,
   input  logic [1:0]            cmd0,
   input  logic [1:0]            cmd1,
   input  logic [SEL-1:0]        rx0,
   input  logic [SEL-1:0]        rx1,
   input  logic [SEL-1:0]        ry0,
   input  logic [SEL-1:0]        ry1,
   input  logic [LARGURA-1:0]    imm0,
   input  logic [LARGURA-1:0]    imm1,
   output logic                  ack0,
   output logic                  ack1,
   output logic [LARGURA-1:0]    resultado,
   output logic                  concede,
   output logic                  ocupado,
   output logic [SEL-1:0]        controle,
   input  logic [LARGURA-1:0]    dado_lido,
   output logic [LARGURA-1:0]    dado_escrita,
   output logic [(2**SEL)-1:0]   habilita_escrita
);
   localparam int NREG = 2**SEL;
   localparam logic [1:0] CARREGA = 2'b00;
   localparam logic [1:0] MOVE    = 2'b01;
   localparam logic [1:0] TROCA   = 2'b10;
   localparam logic [1:0] LE      = 2'b11;

   typedef enum logic [2:0] {OCIOSO, LER_Y, LER_X, ESCREVE_X, ESCREVE_Y, RESPONDE} estado_t;

   estado_t              estado;
   logic                 ultimo;
   logic [1:0]           cmd;
   logic [SEL-1:0]       rx;
   logic [SEL-1:0]       ry;
   logic [LARGURA-1:0]   temp_x;
   logic [LARGURA-1:0]   temp_y;

   logic                 pedido;
   logic                 escolha;
   logic [1:0]           cmd_sel;
   logic [SEL-1:0]       rx_sel;
   logic [SEL-1:0]       ry_sel;
   logic [LARGURA-1:0]   imm_sel;
   logic [LARGURA-1:0]   lido;

   // When both request, the one not served last wins.
   always_comb begin
      pedido  = req0 | req1;
      escolha = (req0 && req1) ? ~ultimo : req1;
      cmd_sel = escolha ? cmd1 : cmd0;
      rx_sel  = escolha ? rx1  : rx0;
      ry_sel  = escolha ? ry1  : ry0;
      imm_sel = escolha ? imm1 : imm0;
   end

`ifdef PROTEGE_R0_EN
   assign lido = (controle == '0) ? '0 : dado_lido;
`else
   assign lido = dado_lido;
`endif

   function automatic logic [NREG-1:0] um_quente(input logic [SEL-1:0] idx);
      logic [NREG-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
`ifdef PROTEGE_R0_EN
      v[0]   = 1'b0;
`endif
      return v;
   endfunction

   // Outputs are registered: each transition loads the values the next state presents.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado           <= OCIOSO;
         ultimo           <= 1'b1;
         cmd              <= CARREGA;
         rx               <= '0;
         ry               <= '0;
         temp_x           <= '0;
         temp_y           <= '0;
         ack0             <= 1'b0;
         ack1             <= 1'b0;
         resultado        <= '0;
         concede          <= 1'b0;
         ocupado          <= 1'b0;
         controle         <= '0;
         dado_escrita     <= '0;
         habilita_escrita <= '0;
      end else begin
         habilita_escrita <= '0;
         ack0             <= 1'b0;
         ack1             <= 1'b0;
         case (estado)
            OCIOSO: begin
               if (pedido) begin
                  cmd     <= cmd_sel;
                  rx      <= rx_sel;
                  ry      <= ry_sel;
                  concede <= escolha;
                  ultimo  <= escolha;
                  ocupado <= 1'b1;
                  case (cmd_sel)
                     CARREGA: begin
                        estado           <= ESCREVE_X;
                        controle         <= rx_sel;
                        dado_escrita     <= imm_sel;
                        habilita_escrita <= um_quente(rx_sel);
                     end
                     MOVE, TROCA: begin
                        estado   <= LER_Y;
                        controle <= ry_sel;
                     end
                     default: begin
                        estado   <= LER_X;
                        controle <= rx_sel;
                     end
                  endcase
               end
            end
            LER_Y: begin
               temp_y   <= lido;
               controle <= rx;
               if (cmd == TROCA) begin
                  estado <= LER_X;
               end else begin
                  estado           <= ESCREVE_X;
                  dado_escrita     <= lido;
                  habilita_escrita <= um_quente(rx);
               end
            end
            LER_X: begin
               temp_x <= lido;
               if (cmd == LE) begin
                  resultado <= lido;
                  estado    <= RESPONDE;
                  controle  <= '0;
                  ack0      <= ~concede;
                  ack1      <= concede;
               end else begin
                  estado           <= ESCREVE_X;
                  controle         <= rx;
                  dado_escrita     <= temp_y;
                  habilita_escrita <= um_quente(rx);
               end
            end
            ESCREVE_X: begin
               if (cmd == TROCA) begin
                  estado           <= ESCREVE_Y;
                  controle         <= ry;
                  dado_escrita     <= temp_x;
                  habilita_escrita <= um_quente(ry);
               end else begin
                  estado   <= RESPONDE;
                  controle <= '0;
                  ack0     <= ~concede;
                  ack1     <= concede;
               end
            end
            ESCREVE_Y: begin
               estado   <= RESPONDE;
               controle <= '0;
               ack0     <= ~concede;
               ack1     <= concede;
            end
            RESPONDE: begin
               estado  <= OCIOSO;
               ocupado <= 1'b0;
            end
            default: begin
               estado   <= OCIOSO;
               ocupado  <= 1'b0;
               controle <= '0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_controlador_banco.sv
// tb/tb_controlador_banco.sv - randomized self-checking bench for controlador_banco
// Honours PROTEGE_R0_EN when the design is built with it.
module tb_controlador_banco;
   localparam int NREG = 8;
`ifdef PROTEGE_R0_EN
   localparam bit PROT = 1'b1;
`else
   localparam bit PROT = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset;
   logic        req0, req1;
   logic [1:0]  cmd0, cmd1;
   logic [2:0]  rx0, rx1, ry0, ry1;
   logic [15:0] imm0, imm1;
   logic        ack0, ack1;
   logic [15:0] resultado;
   logic        concede, ocupado;
   logic [2:0]  controle;
   logic [15:0] dado_lido;
   logic [15:0] dado_escrita;
   logic [7:0]  habilita_escrita;

   controlador_banco #(.LARGURA(16), .SEL(3)) dut (
      .clock(clock), .reset(reset),
      .req0(req0), .req1(req1), .cmd0(cmd0), .cmd1(cmd1),
      .rx0(rx0), .rx1(rx1), .ry0(ry0), .ry1(ry1), .imm0(imm0), .imm1(imm1),
      .ack0(ack0), .ack1(ack1), .resultado(resultado), .concede(concede), .ocupado(ocupado),
      .controle(controle), .dado_lido(dado_lido), .dado_escrita(dado_escrita),
      .habilita_escrita(habilita_escrita)
   );

   always #5 clock = ~clock;

   // Physical bank the controller drives
   logic [15:0] bank [NREG];
   logic [15:0] semente [NREG];
   logic        carrega_banco;
   always @(posedge clock) begin
      if (carrega_banco) begin
         for (int i = 0; i < NREG; i++) bank[i] <= semente[i];
      end else begin
         for (int i = 0; i < NREG; i++) if (habilita_escrita[i]) bank[i] <= dado_escrita;
      end
   end
   assign dado_lido = bank[controle];

   int checks = 0;
   int errors = 0;

   // Reference model: register contents and expected observable effects of one operation
   logic [15:0] modelo [NREG];
   logic [15:0] res_esperado;
   int          exp_lat;
   logic [7:0]  exp_en[$];
   logic [15:0] exp_dado[$];
   logic [2:0]  exp_ctl[$];

   function automatic logic [15:0] ler(input logic [2:0] i);
      return (PROT && i == 3'd0) ? 16'h0000 : modelo[i];
   endfunction

   task automatic escreve(input logic [2:0] i, input logic [15:0] v);
      logic [7:0] oh;
      if (!(PROT && i == 3'd0)) begin
         modelo[i] = v;
         oh = 8'b1 << i;
         exp_en.push_back(oh);
         exp_dado.push_back(v);
         exp_ctl.push_back(i);
      end
   endtask

   task automatic prever(input logic [1:0] c, input logic [2:0] x, input logic [2:0] y, input logic [15:0] im);
      logic [15:0] a, b;
      exp_en.delete(); exp_dado.delete(); exp_ctl.delete();
      case (c)
         2'b00: begin exp_lat = 2; escreve(x, im); end
         2'b01: begin exp_lat = 3; escreve(x, ler(y)); end
         2'b10: begin exp_lat = 5; a = ler(y); b = ler(x); escreve(x, a); escreve(y, b); end
         default: begin exp_lat = 2; res_esperado = ler(x); end
      endcase
   endtask

   // Observations of one operation
   int          lat, quem_ack;
   bit          conc, estourou, ocup_ok, ack_depois, ocup_depois;
   logic [2:0]  ctl1;
   logic [7:0]  en_q[$];
   logic [15:0] dado_q[$];
   logic [2:0]  ctl_q[$];
   int          cyc_q[$];

   task automatic run_op(input int quem, input logic [1:0] c, input logic [2:0] x, input logic [2:0] y,
                         input logic [15:0] im, input bit mexe);
      int cyc;
      en_q.delete(); dado_q.delete(); ctl_q.delete(); cyc_q.delete();
      estourou = 0; lat = 0; quem_ack = -1; ocup_ok = 1; conc = 0;
      if (quem == 0) begin cmd0 = c; rx0 = x; ry0 = y; imm0 = im; req0 = 1; end
      else           begin cmd1 = c; rx1 = x; ry1 = y; imm1 = im; req1 = 1; end
      cyc = 0;
      for (int k = 0; k < 20 && cyc == 0; k++) begin
         @(negedge clock);
         if (ocupado) cyc = 1;
      end
      if (cyc == 0) begin
         estourou = 1; req0 = 0; req1 = 0;
         return;
      end
      ctl1 = controle;
      for (int k = 0; k < 20; k++) begin
         if (habilita_escrita != 8'h00) begin
            en_q.push_back(habilita_escrita); dado_q.push_back(dado_escrita);
            ctl_q.push_back(controle); cyc_q.push_back(cyc);
         end
         if (!ocupado) ocup_ok = 0;
         if (ack0 || ack1) begin
            lat = cyc; quem_ack = (ack0 && ack1) ? 2 : (ack1 ? 1 : 0); conc = concede;
            break;
         end
         if (mexe && cyc == 1) begin
            if (quem == 0) begin cmd0 = 2'($urandom); rx0 = 3'($urandom); ry0 = 3'($urandom); imm0 = 16'($urandom); end
            else           begin cmd1 = 2'($urandom); rx1 = 3'($urandom); ry1 = 3'($urandom); imm1 = 16'($urandom); end
         end
         @(negedge clock);
         cyc++;
      end
      if (lat == 0) estourou = 1;
      req0 = 0; req1 = 0;
      @(negedge clock);
      ack_depois = ack0 | ack1;
      ocup_depois = ocupado;
   endtask

   task automatic test_reset;
      reset = 1; carrega_banco = 1;
      req0 = 0; req1 = 0; cmd0 = 0; cmd1 = 0; rx0 = 0; rx1 = 0; ry0 = 0; ry1 = 0; imm0 = 0; imm1 = 0;
      for (int i = 0; i < NREG; i++) begin semente[i] = 16'($urandom); modelo[i] = semente[i]; end
      res_esperado = 16'h0000;
      repeat (2) @(negedge clock);
      checks++; if ({ack0, ack1, concede, ocupado} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b want 0000", {ack0, ack1, concede, ocupado}); end
      checks++; if (resultado !== 16'h0) begin errors++; $display("FAIL reset_resultado got %h want 0000", resultado); end
      checks++; if (controle !== 3'd0) begin errors++; $display("FAIL reset_controle got %0d want 0", controle); end
      checks++; if (habilita_escrita !== 8'h00) begin errors++; $display("FAIL reset_habilita got %h want 00", habilita_escrita); end
      checks++; if (dado_escrita !== 16'h0) begin errors++; $display("FAIL reset_dado got %h want 0000", dado_escrita); end
      reset = 0; carrega_banco = 0;
      @(negedge clock);
   endtask

   task automatic test_carrega;
      prever(2'b00, 3'd3, 3'd0, 16'hBEEF);
      run_op(0, 2'b00, 3'd3, 3'd0, 16'hBEEF, 1);
      checks++; if (estourou !== 0) begin errors++; $display("FAIL carrega_timeout got %0d want 0", estourou); end
      checks++; if (lat !== 2) begin errors++; $display("FAIL carrega_lat got %0d want 2", lat); end
      checks++; if (en_q.size() !== 1) begin errors++; $display("FAIL carrega_nwrites got %0d want 1", en_q.size()); end
      checks++; if (en_q[0] !== 8'h08) begin errors++; $display("FAIL carrega_en got %h want 08", en_q[0]); end
      checks++; if (dado_q[0] !== 16'hBEEF) begin errors++; $display("FAIL carrega_dado got %h want beef", dado_q[0]); end
      checks++; if (quem_ack !== 0) begin errors++; $display("FAIL carrega_ack got %0d want 0", quem_ack); end
      checks++; if (ocup_ok !== 1) begin errors++; $display("FAIL carrega_ocupado got %0d want 1", ocup_ok); end
      checks++; if ({ack_depois, ocup_depois} !== 2'b00) begin errors++; $display("FAIL carrega_after got %b want 00", {ack_depois, ocup_depois}); end
      checks++; if (bank[3] !== 16'hBEEF) begin errors++; $display("FAIL carrega_bank got %h want beef", bank[3]); end
   endtask

   task automatic test_le;
      prever(2'b11, 3'd3, 3'd0, 16'h0);
      run_op(1, 2'b11, 3'd3, 3'd0, 16'h0, 1);
      checks++; if (ctl1 !== 3'd3) begin errors++; $display("FAIL le_controle got %0d want 3", ctl1); end
      checks++; if (resultado !== 16'hBEEF) begin errors++; $display("FAIL le_resultado got %h want beef", resultado); end
      checks++; if (quem_ack !== 1) begin errors++; $display("FAIL le_ack got %0d want 1", quem_ack); end
      checks++; if (conc !== 1'b1) begin errors++; $display("FAIL le_concede got %0d want 1", conc); end
      checks++; if (lat !== 2) begin errors++; $display("FAIL le_lat got %0d want 2", lat); end
      checks++; if (en_q.size() !== 0) begin errors++; $display("FAIL le_nwrites got %0d want 0", en_q.size()); end
   endtask

   task automatic test_troca;
      prever(2'b00, 3'd1, 3'd0, 16'h1111); run_op(0, 2'b00, 3'd1, 3'd0, 16'h1111, 0);
      prever(2'b00, 3'd2, 3'd0, 16'h2222); run_op(1, 2'b00, 3'd2, 3'd0, 16'h2222, 0);
      prever(2'b10, 3'd1, 3'd2, 16'h0);    run_op(0, 2'b10, 3'd1, 3'd2, 16'h0, 1);
      checks++; if (lat !== 5) begin errors++; $display("FAIL troca_lat got %0d want 5", lat); end
      checks++; if (en_q.size() !== 2) begin errors++; $display("FAIL troca_nwrites got %0d want 2", en_q.size()); end
      checks++; if ({en_q[0], en_q[1]} !== 16'h0204) begin errors++; $display("FAIL troca_en got %h want 0204", {en_q[0], en_q[1]}); end
      checks++; if (cyc_q[1] - cyc_q[0] !== 1) begin errors++; $display("FAIL troca_consec got %0d want 1", cyc_q[1] - cyc_q[0]); end
      checks++; if ({bank[1], bank[2]} !== 32'h2222_1111) begin errors++; $display("FAIL troca_bank got %h want 22221111", {bank[1], bank[2]}); end
   endtask

   task automatic test_reset_meio;
      logic [15:0] a, orig_y;
      bit viu_ack, ok;
      a = ler(3'd6); orig_y = modelo[6];
      cmd0 = 2'b10; rx0 = 3'd5; ry0 = 3'd6; req0 = 1;
      ok = 0;
      for (int k = 0; k < 20 && !ok; k++) begin @(negedge clock); if (ocupado) ok = 1; end
      checks++; if (ok !== 1) begin errors++; $display("FAIL rmeio_grant got %0d want 1", ok); end
      repeat (3) @(negedge clock);
      checks++; if (habilita_escrita !== 8'h40) begin errors++; $display("FAIL rmeio_escreve_y got %h want 40", habilita_escrita); end
      #1 reset = 1;
      #1;
      checks++; if (habilita_escrita !== 8'h00) begin errors++; $display("FAIL rmeio_habilita got %h want 00", habilita_escrita); end
      checks++; if ({ocupado, ack0, ack1} !== 3'b000) begin errors++; $display("FAIL rmeio_flags got %b want 000", {ocupado, ack0, ack1}); end
      req0 = 0;
      viu_ack = 0;
      repeat (2) begin @(negedge clock); viu_ack |= ack0 | ack1; end
      reset = 0;
      repeat (3) begin @(negedge clock); viu_ack |= ack0 | ack1 | ocupado; end
      checks++; if (viu_ack !== 0) begin errors++; $display("FAIL rmeio_no_ack got %0d want 0", viu_ack); end
      if (!(PROT && rx0 == 3'd0)) modelo[5] = a;
      res_esperado = 16'h0000;
      checks++; if (bank[5] !== modelo[5]) begin errors++; $display("FAIL rmeio_rx got %h want %h", bank[5], modelo[5]); end
      checks++; if (bank[6] !== orig_y) begin errors++; $display("FAIL rmeio_ry got %h want %h", bank[6], orig_y); end
   endtask

   task automatic test_arbitragem;
      int ordem[$];
      bit sobe0, sobe1;
      sobe0 = 0; sobe1 = 0;
      cmd0 = 2'b00; rx0 = 3'd4; imm0 = 16'($urandom);
      cmd1 = 2'b00; rx1 = 3'd7; imm1 = 16'($urandom);
      req0 = 1; req1 = 1;
      for (int k = 0; k < 100 && ordem.size() < 4; k++) begin
         @(negedge clock);
         if (sobe0) begin imm0 = 16'($urandom); req0 = 1; sobe0 = 0; end
         if (sobe1) begin imm1 = 16'($urandom); req1 = 1; sobe1 = 0; end
         if (ack0) begin
            ordem.push_back(0); modelo[4] = imm0; req0 = 0; sobe0 = 1;
            checks++; if (concede !== 1'b0) begin errors++; $display("FAIL arb_concede0 got %0d want 0", concede); end
         end
         if (ack1) begin
            ordem.push_back(1); modelo[7] = imm1; req1 = 0; sobe1 = 1;
            checks++; if (concede !== 1'b1) begin errors++; $display("FAIL arb_concede1 got %0d want 1", concede); end
         end
      end
      req0 = 0; req1 = 0;
      repeat (2) @(negedge clock);
      checks++; if (ordem.size() !== 4) begin errors++; $display("FAIL arb_count got %0d want 4", ordem.size()); end
      for (int i = 0; i < ordem.size(); i++) begin
         checks++; if (ordem[i] !== i % 2) begin errors++; $display("FAIL arb_order[%0d] got %0d want %0d", i, ordem[i], i % 2); end
      end
      checks++; if ({bank[4], bank[7]} !== {modelo[4], modelo[7]}) begin errors++; $display("FAIL arb_bank got %h want %h", {bank[4], bank[7]}, {modelo[4], modelo[7]}); end
   endtask

   task automatic test_r0;
      prever(2'b00, 3'd0, 3'd0, 16'hFFFF);
      run_op(0, 2'b00, 3'd0, 3'd0, 16'hFFFF, 0);
      checks++; if (en_q.size() !== exp_en.size()) begin errors++; $display("FAIL r0_nwrites got %0d want %0d", en_q.size(), exp_en.size()); end
      checks++; if (lat !== 2) begin errors++; $display("FAIL r0_lat got %0d want 2", lat); end
      prever(2'b11, 3'd0, 3'd0, 16'h0);
      run_op(1, 2'b11, 3'd0, 3'd0, 16'h0, 0);
      checks++; if (resultado !== res_esperado) begin errors++; $display("FAIL r0_le got %h want %h", resultado, res_esperado); end
   endtask

   task automatic test_aleatorio;
      logic [1:0] c; logic [2:0] x, y; logic [15:0] im; int quem;
      for (int n = 0; n < 40; n++) begin
         quem = int'($urandom_range(0, 1));
         c = 2'($urandom); x = 3'($urandom); y = 3'($urandom); im = 16'($urandom);
         if (n == 0) begin c = 2'b10; x = 3'd7; y = 3'd7; end
         if (n == 1) begin c = 2'b01; y = x; end
         if (n == 2) begin c = 2'b11; x = 3'd7; end
         prever(c, x, y, im);
         run_op(quem, c, x, y, im, 1);
         checks++; if (estourou !== 0) begin errors++; $display("FAIL rnd%0d_timeout got %0d want 0", n, estourou); end
         checks++; if (lat !== exp_lat) begin errors++; $display("FAIL rnd%0d_lat cmd %0d got %0d want %0d", n, c, lat, exp_lat); end
         checks++; if (quem_ack !== quem || conc !== quem[0]) begin errors++; $display("FAIL rnd%0d_ack got %0d/%0d want %0d", n, quem_ack, conc, quem); end
         checks++; if (en_q.size() !== exp_en.size()) begin errors++; $display("FAIL rnd%0d_nwrites got %0d want %0d", n, en_q.size(), exp_en.size()); end
         for (int i = 0; i < en_q.size() && i < exp_en.size(); i++) begin
            checks++;
            if (en_q[i] !== exp_en[i] || dado_q[i] !== exp_dado[i] || ctl_q[i] !== exp_ctl[i]) begin
               errors++; $display("FAIL rnd%0d_write%0d got %h/%h/%0d want %h/%h/%0d", n, i, en_q[i], dado_q[i], ctl_q[i], exp_en[i], exp_dado[i], exp_ctl[i]);
            end
         end
         checks++; if ({ack_depois, ocup_depois, ocup_ok} !== 3'b001) begin errors++; $display("FAIL rnd%0d_handshake got %b want 001", n, {ack_depois, ocup_depois, ocup_ok}); end
         checks++; if (resultado !== res_esperado) begin errors++; $display("FAIL rnd%0d_resultado got %h want %h", n, resultado, res_esperado); end
         for (int i = 0; i < NREG; i++) begin
            checks++; if (bank[i] !== modelo[i]) begin errors++; $display("FAIL rnd%0d_bank%0d got %h want %h", n, i, bank[i], modelo[i]); end
         end
      end
   endtask

   initial begin
      test_reset;
      test_carrega;
      test_le;
      test_troca;
      test_reset_meio;
      test_arbitragem;
      test_r0;
      test_aleatorio;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/controlador_banco.md
Name: controlador_banco

Overview:
- Sequencer/arbiter for the 8 x 16-bit register bank: drives the bank's 3-bit read-select mux (`controle`), the one-hot write enables and the write data.
- Executes multi-cycle register operations (load, move, swap, read) on behalf of two requesters.
- Shares the bank between the two requesters using round-robin arbitration with a level req / pulse ack handshake.

Parameters:
- LARGURA, 16, data width of bank registers
- SEL, 3, register index width; bank holds 2**SEL registers

Ports:
- clock  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- req0 / req1  in  1  request from requester 0 / 1, held high until ack
- cmd0 / cmd1  in  2  operation code (00 CARREGA, 01 MOVE, 10 TROCA, 11 LE)
- rx0 / rx1  in  SEL  destination / primary register index
- ry0 / ry1  in  SEL  source / secondary register index
- imm0 / imm1  in  LARGURA  immediate for CARREGA
- ack0 / ack1  out  1  one-cycle completion pulse to requester 0 / 1
- resultado  out  LARGURA  read data for LE; held until next LE completes
- concede  out  1  index of requester currently or last granted
- ocupado  out  1  high whenever FSM is not OCIOSO
- controle  out  SEL  read select to bank mux
- dado_lido  in  LARGURA  mux output (combinational from controle)
- dado_escrita  out  LARGURA  write data to bank
- habilita_escrita  out  2**SEL  one-hot write enables; bank writes on clock edge

Behaviour:
- Reset values: ack0/ack1=0, resultado=0, concede=0, ocupado=0, controle=0, dado_escrita=0, habilita_escrita=0, FSM=OCIOSO, ultimo=1 (so req0 wins first). Reset is async: outputs clear immediately, including mid-operation.
- FSM states: OCIOSO, LER_Y, LER_X, ESCREVE_X, ESCREVE_Y, RESPONDE.
- Grant and latch in OCIOSO:
  - Only one request pending: grant it.
  - Both pending: grant the requester != ultimo.
  - On the grant edge: latch cmd/rx/ry/imm, set concede, set ultimo to the granted index.
- Command sequences:
  - CARREGA: ESCREVE_X (data=imm) -> RESPONDE.
  - MOVE: LER_Y (temp_y<=dado_lido) -> ESCREVE_X (data=temp_y) -> RESPONDE.
  - TROCA: LER_Y -> LER_X (temp_x<=dado_lido) -> ESCREVE_X (data=temp_y) -> ESCREVE_Y (data=temp_x) -> RESPONDE.
  - LE: LER_X -> RESPONDE; resultado<=temp_x.
- Select and write enable:
  - controle = ry in LER_Y/ESCREVE_Y, rx in LER_X/ESCREVE_X, 0 otherwise.
  - habilita_escrita has exactly one bit high, for exactly one cycle, per write state; all zero in every other state.
- RESPONDE: ack of the granted requester high for 1 cycle, then OCIOSO.
- Requester must drop req in the cycle after ack; req still high in OCIOSO is a new request.
- Latency, grant edge to ack high (cycles): CARREGA 2, LE 2, MOVE 3, TROCA 5.
- Back-to-back: the next grant can occur on the edge leaving RESPONDE+1 (OCIOSO lasts at least one cycle).
- Boundary cases:
  - rx==ry on TROCA/MOVE: full sequence still runs; register value unchanged.
  - Index 7: enable bit 7, no wrap.
  - Changes on cmd/rx/ry/imm after grant are ignored.
- Reset mid-TROCA between ESCREVE_X and ESCREVE_Y leaves Rx updated and Ry unchanged. This is acceptable and no ack is issued.

Optional Feature:
- Macro PROTEGE_R0_EN.
- Defined: register 0 is hard zero. habilita_escrita[0] is never asserted; write states targeting R0 still consume their cycle. LE/MOVE/TROCA reads of R0 capture 0 regardless of dado_lido.
- Undefined: R0 is an ordinary register.

Test Plan:
- Reset, req0 CARREGA rx=3 imm=0xBEEF -> one cycle habilita_escrita=0x08, dado_escrita=0xBEEF; ack0 2 cycles after grant; ocupado high meanwhile.
- Then req1 LE rx=3 (bench bank model) -> controle=3 in LER_X, resultado=0xBEEF, ack1 pulse, concede=1.
- R1=0x1111, R2=0x2222, TROCA rx=1 ry=2 -> enables 0x02 then 0x04 on consecutive cycles; R1=0x2222, R2=0x1111; ack 5 cycles after grant.
- req0 and req1 both high from reset with CARREGA -> req0 served first, then req1; repeat both high -> order alternates 0,1,0,1.
- Assert reset during ESCREVE_Y of TROCA -> habilita_escrita, ack, ocupado go 0 without a clock edge; no ack; FSM OCIOSO after release.
- PROTEGE_R0_EN defined: CARREGA rx=0 imm=0xFFFF -> habilita_escrita stays 0, ack after 2 cycles; LE rx=0 -> resultado=0.
